// File: rtl/netlist_eval_pkg.sv
// netlist_eval_pkg
//   Shared types and constants for the NAND/NOR netlist evaluator.
//   Holds the table geometry, the signal index map, the gate record
//   layout, the controller states, and a helper that resolves a signal
//   index against the current signal file.
//   Optional feature macro used by the top: NETLIST_EVAL_IDXCHK_EN.

package netlist_eval_pkg;

    localparam int NUM_IN    = 5;
    localparam int MAX_GATES = 16;
    localparam int SIG_W     = $clog2(2 + NUM_IN + MAX_GATES);
    localparam int CNT_W     = $clog2(MAX_GATES + 1);
    localparam int PTR_W     = $clog2(MAX_GATES);
    localparam int SIG_N     = 2 ** SIG_W;

    // Signal index map: constants, then primary inputs, then gate outputs.
    localparam int IDX_ZERO  = 0;
    localparam int IDX_ONE   = 1;
    localparam int IDX_IN0   = 2;
    localparam int IDX_GATE0 = IDX_IN0 + NUM_IN;

    typedef enum logic {
        OP_NAND = 1'b0,
        OP_NOR  = 1'b1
    } gate_op_t;

    typedef struct packed {
        gate_op_t         op;
        logic [SIG_W-1:0] a;
        logic [SIG_W-1:0] b;
    } gate_rec_t;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    // Builds the full addressable signal space so any index, including
    // those past the last gate output, resolves with a single select.
    // Unused upper indices stay 0.
    function automatic logic sig_val(
        input logic [SIG_W-1:0]     idx,
        input logic [NUM_IN-1:0]    ins,
        input logic [MAX_GATES-1:0] gates
    );
        logic [SIG_N-1:0] sigs;
        sigs                         = '0;
        sigs[IDX_ZERO]               = 1'b0;
        sigs[IDX_ONE]                = 1'b1;
        sigs[IDX_IN0 +: NUM_IN]      = ins;
        sigs[IDX_GATE0 +: MAX_GATES] = gates;
        return sigs[idx];
    endfunction

endpackage

// File: rtl/netlist_eval_gate.sv
// netlist_eval_gate
//   Combinational two-input gate cell used by the evaluator datapath.
//   Ports:
//     op  gate type (OP_NAND / OP_NOR)
//     a   input A value
//     b   input B value
//     y   gate output

module netlist_eval_gate
    import netlist_eval_pkg::*;
(
    input  gate_op_t op,
    input  logic     a,
    input  logic     b,
    output logic     y
);

    always_comb begin
        if (op == OP_NOR) y = ~(a | b);
        else              y = ~(a & b);
    end

endmodule

// File: rtl/netlist_eval.sv
// netlist_eval
//   Sequential evaluator for two-input NAND/NOR netlists. Gate records are
//   loaded over a valid/ready port into a table; a start pulse latches the
//   primary inputs and output select, evaluates one gate per cycle in table
//   order, and presents the selected signal on a valid/ready result port.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     gate_valid/ready    gate record handshake
//     gate_op/a/b         gate record (0=NAND, 1=NOR; signal indices)
//     clear               empty the gate table (pulse, idle only)
//     start               begin evaluation (pulse, idle only)
//     in_vec, out_sel     primary inputs / result signal, sampled on start
//     busy                evaluation in progress
//     res_valid/ready     result handshake
//     res_data            result value
//     gate_count          number of loaded gates
//     err                 only with NETLIST_EVAL_IDXCHK_EN: sticky flag for
//                         a rejected forward/undefined reference
//   Optional feature macro: NETLIST_EVAL_IDXCHK_EN.

module netlist_eval
    import netlist_eval_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gate_valid,
    output logic              gate_ready,
    input  logic              gate_op,
    input  logic [SIG_W-1:0]  gate_a,
    input  logic [SIG_W-1:0]  gate_b,
    input  logic              clear,
    input  logic              start,
    input  logic [NUM_IN-1:0] in_vec,
    input  logic [SIG_W-1:0]  out_sel,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_data,
    output logic [CNT_W-1:0]  gate_count
`ifdef NETLIST_EVAL_IDXCHK_EN
    ,
    output logic              err
`endif
);

    state_t               state;
    state_t               state_next;
    gate_rec_t            gate_table [MAX_GATES];
    logic [PTR_W-1:0]     p;
    logic [NUM_IN-1:0]    in_lat;
    logic [SIG_W-1:0]     out_sel_lat;
    logic [MAX_GATES-1:0] gate_out;
    logic [MAX_GATES-1:0] gate_out_next;
    gate_rec_t            cur;
    logic                 a_val;
    logic                 b_val;
    logic                 y_val;
    logic                 accept;
    logic                 bad_ref;
    logic                 store;
    logic                 empty_on_start;
    logic                 last_gate;

    // A record is handshaken whenever valid meets ready; it is written to
    // the table only if it is not cancelled by clear and passes the
    // optional reference check.
    always_comb begin
        accept = gate_valid && gate_ready;
`ifdef NETLIST_EVAL_IDXCHK_EN
        bad_ref = (int'(gate_a) >= IDX_GATE0 + int'(gate_count)) ||
                  (int'(gate_b) >= IDX_GATE0 + int'(gate_count));
`else
        bad_ref = 1'b0;
`endif
        store = accept && !clear && !bad_ref;
        // Start sees the table after this cycle's clear/accept.
        empty_on_start = clear || ((gate_count == '0) && !store);
        last_gate      = (CNT_W'(p) + CNT_W'(1)) == gate_count;
    end

    // Evaluation datapath: operands read the current signal file, so a
    // reference to a gate not yet evaluated this pass returns 0.
    always_comb begin
        cur   = gate_table[p];
        a_val = sig_val(cur.a, in_lat, gate_out);
        b_val = sig_val(cur.b, in_lat, gate_out);
        gate_out_next    = gate_out;
        gate_out_next[p] = y_val;
    end

    netlist_eval_gate u_gate (
        .op (cur.op),
        .a  (a_val),
        .b  (b_val),
        .y  (y_val)
    );

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        gate_ready = 1'b0;
        busy       = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                gate_ready = gate_count < CNT_W'(MAX_GATES);
                if (start) state_next = empty_on_start ? DONE : EVAL;
            end
            EVAL: begin
                busy = 1'b1;
                if (last_gate) state_next = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control and signal-file registers. res_data is captured once, on the
    // transition into DONE, so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gate_count  <= '0;
            p           <= '0;
            in_lat      <= '0;
            out_sel_lat <= '0;
            gate_out    <= '0;
            res_data    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (clear)      gate_count <= '0;
                    else if (store) gate_count <= gate_count + CNT_W'(1);
                    if (start) begin
                        in_lat      <= in_vec;
                        out_sel_lat <= out_sel;
                        gate_out    <= '0;
                        p           <= '0;
                        if (empty_on_start)
                            res_data <= sig_val(out_sel, in_vec, '0);
                    end
                end
                EVAL: begin
                    gate_out <= gate_out_next;
                    p        <= p + PTR_W'(1);
                    if (last_gate)
                        res_data <= sig_val(out_sel_lat, in_lat, gate_out_next);
                end
                default: ;
            endcase
        end
    end

    // Gate table storage; contents persist until overwritten after a clear.
    always_ff @(posedge clk) begin
        if (state == IDLE && store)
            gate_table[gate_count[PTR_W-1:0]] <= '{op: gate_op_t'(gate_op), a: gate_a, b: gate_b};
    end

`ifdef NETLIST_EVAL_IDXCHK_EN
    // Sticky reference-error flag, cleared together with the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE) begin
            if (clear)                   err <= 1'b0;
            else if (accept && bad_ref)  err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_netlist_eval.sv
// tb_netlist_eval
//   Self-checking bench for netlist_eval. A queue-based reference model
//   evaluates the loaded netlist with plain arithmetic over a signal array.

module tb_netlist_eval;
    import netlist_eval_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              gate_valid;
    logic              gate_ready;
    logic              gate_op;
    logic [SIG_W-1:0]  gate_a;
    logic [SIG_W-1:0]  gate_b;
    logic              clear;
    logic              start;
    logic [NUM_IN-1:0] in_vec;
    logic [SIG_W-1:0]  out_sel;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic              res_data;
    logic [CNT_W-1:0]  gate_count;
`ifdef NETLIST_EVAL_IDXCHK_EN
    logic              err;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit op;
        int a;
        int b;
    } ref_gate_t;

    ref_gate_t model[$];

    netlist_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gate_valid (gate_valid),
        .gate_ready (gate_ready),
        .gate_op    (gate_op),
        .gate_a     (gate_a),
        .gate_b     (gate_b),
        .clear      (clear),
        .start      (start),
        .in_vec     (in_vec),
        .out_sel    (out_sel),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .gate_count (gate_count)
`ifdef NETLIST_EVAL_IDXCHK_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    // Reference: constants, inputs, then gates evaluated in order over a
    // zero-initialised signal array; anything unassigned reads 0.
    function automatic bit modelEval(input logic [NUM_IN-1:0] ins, input int sel);
        bit s[32];
        bit x;
        bit y;
        foreach (s[k]) s[k] = 1'b0;
        s[1] = 1'b1;
        for (int i = 0; i < NUM_IN; i++) s[2 + i] = ins[i];
        for (int i = 0; i < model.size(); i++) begin
            x = s[model[i].a];
            y = s[model[i].b];
            s[2 + NUM_IN + i] = model[i].op ? !(x | y) : !(x & y);
        end
        return s[sel];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one gate record for one cycle; it is accepted if ready was
    // high going into the edge.
    task automatic applyStimulus(input bit op, input int a, input int b, output bit accepted);
        ref_gate_t g;
        gate_valid = 1'b1;
        gate_op    = op;
        gate_a     = SIG_W'(a);
        gate_b     = SIG_W'(b);
        accepted   = gate_ready;
        stepCycle();
        gate_valid = 1'b0;
        if (accepted) begin
            g.op = op;
            g.a  = a;
            g.b  = b;
            model.push_back(g);
        end
    endtask

    // Waits (bounded) for res_valid after the start edge, then checks the
    // latency and value. Latency counts cycles from the start cycle.
    task automatic waitResult(input string tag, input int exp_lat, input bit exp_data);
        int lat;
        lat = 1;
        while (!res_valid && lat < 200) begin
            stepCycle();
            lat++;
        end
        checkOutput({tag, "_lat"}, lat, exp_lat);
        checkOutput({tag, "_data"}, res_data, exp_data);
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        stepCycle();
        res_ready = 1'b0;
        checkOutput({tag, "_ack"}, res_valid, 1'b0);
    endtask

    task automatic runEval(input string tag, input logic [NUM_IN-1:0] ins, input int sel);
        int exp_lat;
        bit exp_data;
        exp_lat  = model.size() + 1;
        exp_data = modelEval(ins, sel);
        start    = 1'b1;
        in_vec   = ins;
        out_sel  = SIG_W'(sel);
        stepCycle();
        start    = 1'b0;
        waitResult(tag, exp_lat, exp_data);
        consume(tag);
    endtask

    initial begin
        bit acc;
        bit held;
        bit exp_data;
        logic [NUM_IN-1:0] rv;
        int rs;

        rst_n      = 1'b0;
        gate_valid = 1'b0;
        gate_op    = 1'b0;
        gate_a     = '0;
        gate_b     = '0;
        clear      = 1'b0;
        start      = 1'b0;
        in_vec     = '0;
        out_sel    = '0;
        res_ready  = 1'b0;
        stepCycle();
        stepCycle();

        // Reset values.
        checkOutput("rst_ready", gate_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_valid", res_valid, 1'b0);
        checkOutput("rst_data", res_data, 1'b0);
        checkOutput("rst_count", gate_count, 0);
        rst_n = 1'b1;
        stepCycle();

        // Directed netlist: res = a&b&~(~c&d&e) on signal 16.
        applyStimulus(1'b0, 2, 3, acc);
        applyStimulus(1'b0, 5, 1, acc);
        applyStimulus(1'b0, 6, 1, acc);
        applyStimulus(1'b0, 7, 1, acc);
        applyStimulus(1'b1, 4, 8, acc);
        applyStimulus(1'b0, 11, 1, acc);
        applyStimulus(1'b1, 12, 9, acc);
        applyStimulus(1'b0, 13, 1, acc);
        applyStimulus(1'b0, 10, 14, acc);
        applyStimulus(1'b0, 15, 1, acc);
        checkOutput("load10_count", gate_count, 10);

        runEval("case1", 5'b11011, 16);
        runEval("case2a", 5'b11111, 16);
        runEval("case2b", 5'b00011, 16);
        for (int i = 0; i < 6; i++) begin
            rv = NUM_IN'($urandom_range(0, 31));
            rs = $urandom_range(0, 31);
            runEval($sformatf("rnd10_%0d", i), rv, rs);
        end

        // Backpressure: result held, start pulses ignored in DONE.
        rv       = 5'b10111;
        exp_data = modelEval(rv, 16);
        start    = 1'b1;
        in_vec   = rv;
        out_sel  = SIG_W'(16);
        stepCycle();
        start    = 1'b0;
        waitResult("bp", model.size() + 1, exp_data);
        held = res_data;
        for (int i = 0; i < 5; i++) begin
            start  = (i % 2 == 0);
            in_vec = ~rv;
            stepCycle();
            checkOutput($sformatf("bp_valid_%0d", i), res_valid, 1'b1);
            checkOutput($sformatf("bp_data_%0d", i), res_data, exp_data);
            checkOutput($sformatf("bp_busy_%0d", i), busy, 1'b0);
        end
        start = 1'b0;
        checkOutput("bp_held", res_data, held);
        consume("bp");

        // Clear wins over a simultaneous accept.
        gate_valid = 1'b1;
        gate_op    = 1'b0;
        gate_a     = SIG_W'(2);
        gate_b     = SIG_W'(3);
        clear      = 1'b1;
        stepCycle();
        gate_valid = 1'b0;
        clear      = 1'b0;
        model.delete();
        checkOutput("clear_count", gate_count, 0);
        checkOutput("clear_ready", gate_ready, 1'b1);

        // Empty table.
        runEval("empty_one", 5'b00000, 1);
        runEval("empty_in0", 5'b00001, 2);
        runEval("empty_gate", 5'b11111, 7);

        // Start and accept in the same cycle: the new gate is evaluated.
        begin
            ref_gate_t g;
            rv         = 5'b00001;
            gate_valid = 1'b1;
            gate_op    = 1'b0;
            gate_a     = SIG_W'(2);
            gate_b     = SIG_W'(2);
            start      = 1'b1;
            in_vec     = rv;
            out_sel    = SIG_W'(7);
            g.op = 1'b0;
            g.a  = 2;
            g.b  = 2;
            model.push_back(g);
            exp_data   = modelEval(rv, 7);
            stepCycle();
            gate_valid = 1'b0;
            start      = 1'b0;
            waitResult("start_acc", 2, exp_data);
            consume("start_acc");
            checkOutput("start_acc_count", gate_count, 1);
        end

        // Random full table, including forward and out-of-range references.
        clear = 1'b1;
        stepCycle();
        clear = 1'b0;
        model.delete();
        for (int i = 0; i < MAX_GATES; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 31), acc);
        end
        checkOutput("full_count", gate_count, MAX_GATES);
        checkOutput("full_ready", gate_ready, 1'b0);
        applyStimulus(1'b0, 2, 3, acc);
        checkOutput("full_stall_acc", acc, 1'b0);
        stepCycle();
        checkOutput("full_stall_count", gate_count, MAX_GATES);
        for (int i = 0; i < 6; i++) begin
            rv = NUM_IN'($urandom_range(0, 31));
            rs = $urandom_range(0, 31);
            runEval($sformatf("rnd16_%0d", i), rv, rs);
        end

        // Reset during evaluation aborts and empties the table count.
        start   = 1'b1;
        in_vec  = 5'b01010;
        out_sel = SIG_W'(22);
        stepCycle();
        start   = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_valid", res_valid, 1'b0);
        checkOutput("abort_count", gate_count, 0);
        checkOutput("abort_ready", gate_ready, 1'b1);
        checkOutput("abort_data", res_data, 1'b0);
        stepCycle();
        rst_n = 1'b1;
        model.delete();
        stepCycle();
        runEval("post_rst", 5'b00000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
